// File: rtl/overlay_compositor.sv
// Pixel-domain overlay compositor: priority-merges 1-bit layers over a background,
// with a frame-counted blink phase and sync delay matched to the upstream read latency.
module overlay_compositor #(
  parameter int LAYERS       = 3,
  parameter int COLOUR_BITS  = 8,
  parameter int SYNC_DELAY   = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                                   i_clk_pxl,
  input  logic                                   i_rst_n,
  input  logic                                   i_de,
  input  logic                                   i_hsync,
  input  logic                                   i_vsync,
  input  logic [LAYERS-1:0]                      i_layer_dv,
  input  logic [LAYERS-1:0]                      i_layer_data,
  input  logic [LAYERS-1:0][3*COLOUR_BITS-1:0]   i_layer_colour,
  input  logic [LAYERS-1:0]                      i_layer_blink,
  input  logic [3*COLOUR_BITS-1:0]               i_bg_colour,
  output logic [COLOUR_BITS-1:0]                 o_r,
  output logic [COLOUR_BITS-1:0]                 o_g,
  output logic [COLOUR_BITS-1:0]                 o_b,
  output logic                                   o_de,
  output logic                                   o_hsync,
  output logic                                   o_vsync,
  output logic                                   o_blink_phase
);

  localparam int PW = 3 * COLOUR_BITS;
  localparam int CW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  logic [SYNC_DELAY:0] de_sr, hs_sr, vs_sr;
  logic                de_next;
  logic                vs_q, vs_armed, frame_tick, blink_phase;
  logic [CW-1:0]       frame_cnt;
  logic [PW-1:0]       pix_sel, pix_next, pix_q;

  always_ff @(posedge i_clk_pxl) begin
    if (!i_rst_n) begin
      de_sr <= '0;
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      de_sr[0] <= i_de;
      hs_sr[0] <= i_hsync;
      vs_sr[0] <= i_vsync;
      for (int i = 1; i <= SYNC_DELAY; i++) begin
        de_sr[i] <= de_sr[i-1];
        hs_sr[i] <= hs_sr[i-1];
        vs_sr[i] <= vs_sr[i-1];
      end
    end
  end

  // de value that lands in the last stage on the same edge as the pixel register
  generate
    if (SYNC_DELAY == 0) begin : g_de_direct
      assign de_next = i_de;
    end else begin : g_de_tap
      assign de_next = de_sr[SYNC_DELAY-1];
    end
  endgenerate

  assign o_de    = de_sr[SYNC_DELAY];
  assign o_hsync = hs_sr[SYNC_DELAY];
  assign o_vsync = vs_sr[SYNC_DELAY];

  // vs_armed blocks a vsync already high at reset release from counting as a tick
  assign frame_tick = i_vsync & ~vs_q & vs_armed;

  always_ff @(posedge i_clk_pxl) begin
    if (!i_rst_n) begin
      vs_q        <= 1'b0;
      vs_armed    <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      vs_q <= i_vsync;
      if (!i_vsync) vs_armed <= 1'b1;
      if (frame_tick) begin
        if (frame_cnt == CNT_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + CW'(1);
        end
      end
    end
  end

  assign o_blink_phase = blink_phase;

  // descending scan so the lowest-indexed opaque layer wins
  always_comb begin
    pix_sel = i_bg_colour;
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (i_layer_dv[k] && i_layer_data[k] && !(i_layer_blink[k] && !blink_phase))
        pix_sel = i_layer_colour[k];
    end
    pix_next = de_next ? pix_sel : '0;
  end

  always_ff @(posedge i_clk_pxl) begin
    if (!i_rst_n) pix_q <= '0;
    else          pix_q <= pix_next;
  end

  assign o_r = pix_q[3*COLOUR_BITS-1:2*COLOUR_BITS];
  assign o_g = pix_q[2*COLOUR_BITS-1:COLOUR_BITS];
  assign o_b = pix_q[COLOUR_BITS-1:0];

endmodule

// File: tb/tb_overlay_compositor.sv
// Directed bench: main instance (SYNC_DELAY=2, BLINK_FRAMES=2) and an edge-case
// instance (SYNC_DELAY=0, BLINK_FRAMES=1) sharing the same stimulus.
module tb_overlay_compositor;

  logic              clk = 1'b0;
  logic              rst_n, de, hsync, vsync;
  logic [2:0]        layer_dv, layer_data, layer_blink;
  logic [2:0][23:0]  layer_colour;
  logic [23:0]       bg_colour;

  logic [7:0] r1, g1, b1, r2, g2, b2;
  logic       de1, hs1, vs1, ph1, de2, hs2, vs2, ph2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  overlay_compositor #(.LAYERS(3), .COLOUR_BITS(8), .SYNC_DELAY(2), .BLINK_FRAMES(2)) dut (
    .i_clk_pxl(clk), .i_rst_n(rst_n), .i_de(de), .i_hsync(hsync), .i_vsync(vsync),
    .i_layer_dv(layer_dv), .i_layer_data(layer_data), .i_layer_colour(layer_colour),
    .i_layer_blink(layer_blink), .i_bg_colour(bg_colour),
    .o_r(r1), .o_g(g1), .o_b(b1), .o_de(de1), .o_hsync(hs1), .o_vsync(vs1),
    .o_blink_phase(ph1));

  overlay_compositor #(.LAYERS(3), .COLOUR_BITS(8), .SYNC_DELAY(0), .BLINK_FRAMES(1)) dut_edge (
    .i_clk_pxl(clk), .i_rst_n(rst_n), .i_de(de), .i_hsync(hsync), .i_vsync(vsync),
    .i_layer_dv(layer_dv), .i_layer_data(layer_data), .i_layer_colour(layer_colour),
    .i_layer_blink(layer_blink), .i_bg_colour(bg_colour),
    .o_r(r2), .o_g(g2), .o_b(b2), .o_de(de2), .o_hsync(hs2), .o_vsync(vs2),
    .o_blink_phase(ph2));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    cyc();
  endtask

  bit exp_ph1 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit exp_ph2 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
    layer_dv = '0; layer_data = '0; layer_blink = '0;
    layer_colour[0] = 24'hAABBCC;
    layer_colour[1] = 24'hFF0000;
    layer_colour[2] = 24'h00FF00;
    bg_colour = 24'h000000;
    cyc(); cyc();
    check("rst_rgb", {r1, g1, b1}, 24'h0);
    check("rst_de", de1, 1'b0);
    check("rst_hs", hs1, 1'b0);
    check("rst_vs", vs1, 1'b0);
    check("rst_phase", ph1, 1'b1);
    check("rst_phase_edge", ph2, 1'b1);
    rst_n = 1'b1;
    cyc(); cyc(); cyc();

    // alignment: de pulse at edge A, layer0 data presented two cycles later
    bg_colour = 24'h000080;
    de = 1'b1; hsync = 1'b1;
    cyc();
    check("align_edge_de", de2, 1'b1);
    check("align_edge_rgb", {r2, g2, b2}, 24'h000080);
    check("align_de_a0", de1, 1'b0);
    de = 1'b0; hsync = 1'b0;
    cyc();
    check("align_de_a1", de1, 1'b0);
    check("align_edge_de_off", de2, 1'b0);
    layer_dv = 3'b001; layer_data = 3'b001;
    cyc();
    check("align_de_a2", de1, 1'b1);
    check("align_hs_a2", hs1, 1'b1);
    check("align_rgb_a2", {r1, g1, b1}, 24'hAABBCC);
    layer_dv = '0; layer_data = '0;
    cyc();
    check("align_de_a3", de1, 1'b0);
    check("align_rgb_a3", {r1, g1, b1}, 24'h0);

    // priority
    de = 1'b1; layer_dv = 3'b110; layer_data = 3'b110;
    cyc(); cyc(); cyc();
    check("prio_l1", {r1, g1, b1}, 24'hFF0000);
    layer_dv = 3'b100;
    cyc();
    check("prio_l2", {r1, g1, b1}, 24'h00FF00);
    layer_dv = 3'b000; layer_data = 3'b000;
    cyc();
    check("prio_bg", {r1, g1, b1}, 24'h000080);
    check("prio_bg_edge", {r2, g2, b2}, 24'h000080);

    // blanking
    de = 1'b0; layer_dv = 3'b001; layer_data = 3'b001; bg_colour = 24'hFFFFFF;
    cyc(); cyc(); cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("blank_rgb", {r1, g1, b1}, 24'h0);
      check("blank_rgb_edge", {r2, g2, b2}, 24'h0);
    end

    // blink
    de = 1'b1; bg_colour = 24'h000080; layer_blink = 3'b001;
    cyc(); cyc(); cyc();
    check("blink_init_rgb", {r1, g1, b1}, 24'hAABBCC);
    for (int i = 0; i < 4; i++) begin
      vsync = 1'b1;
      cyc();
      check("blink_phase", ph1, exp_ph1[i]);
      check("blink_phase_edge", ph2, exp_ph2[i]);
      vsync = 1'b0;
      cyc();
      check("blink_rgb", {r1, g1, b1}, exp_ph1[i] ? 24'hAABBCC : 24'h000080);
      check("blink_rgb_edge", {r2, g2, b2}, exp_ph2[i] ? 24'hAABBCC : 24'h000080);
    end
    vs_pulse(); vs_pulse(); vs_pulse();
    check("pre_rst_phase", ph1, 1'b0);

    // reset mid-frame with phase=0, count=1; vsync held high across release
    vsync = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("mid_rst_rgb", {r1, g1, b1}, 24'h0);
      check("mid_rst_de", de1, 1'b0);
      check("mid_rst_vs", vs1, 1'b0);
      check("mid_rst_phase", ph1, 1'b1);
      check("mid_rst_phase_edge", ph2, 1'b1);
    end
    rst_n = 1'b1;
    cyc();
    check("resume_de_1", de1, 1'b0);
    cyc();
    check("resume_de_2", de1, 1'b0);
    cyc();
    check("resume_de_3", de1, 1'b1);
    check("resume_rgb", {r1, g1, b1}, 24'hAABBCC);
    check("held_vs_phase", ph1, 1'b1);
    check("held_vs_phase_edge", ph2, 1'b1);
    vsync = 1'b0;
    cyc();
    vsync = 1'b1;
    cyc();
    check("post_rst_tick1", ph1, 1'b1);
    check("post_rst_tick1_edge", ph2, 1'b0);
    vsync = 1'b0;
    cyc();
    vsync = 1'b1;
    cyc();
    check("post_rst_tick2", ph1, 1'b0);
    check("post_rst_tick2_edge", ph2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
